// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: CPU stores to TXDATA are queued and sent 8N1 LSB-first on tx; MMIO_UART_TX_PARITY_EN adds even parity.
// Start bit drives from the edge after the push; stores while full are dropped and flag STATUS overflow.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_vld,
  input  logic [WIDTH-1:0]       wr_dat,
  input  logic                   rd_rdy,
  output logic [WIDTH-1:0]       rd_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             wr_acc, rd_acc;

  assign rd_acc = rd_rdy && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign wr_acc = wr_vld && (!full || rd_acc);
  assign full   = count == (AW+1)'(DEPTH);
  assign empty  = count == '0;
  assign rd_dat = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      if (wr_acc && !rd_acc)      count <= count + 1'b1;
      else if (rd_acc && !wr_acc) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr] <= wr_dat;
  end
endmodule

module mmio_uart_tx #(
  parameter int          CLK_HZ    = 50_000_000,
  parameter int          BAUD      = 115200,
  parameter int          DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400
) (
  input  logic        clkFPGA,
  input  logic        rst,
  input  logic        mem_we,
  input  logic        mem_re,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);
  localparam int          DIV         = CLK_HZ / BAUD;
  localparam int          BW          = $clog2(DIV);
  localparam int          CW          = $clog2(DEPTH) + 1;
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd1;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic [7:0]    shift;
  logic [2:0]    bitn;
  logic [BW-1:0] baud;
  logic          ovf;
  logic          push_req, stat_sel, pop, baud_end;
  logic          full, empty;
  logic [7:0]    fifo_dat;
  logic [CW-1:0] fcount;
  logic          unused_wdata;

  assign unused_wdata = ^wdata[31:8];
  assign push_req = mem_we && (addr == BASE_ADDR);
  assign stat_sel = addr == STATUS_ADDR;
  assign baud_end = baud == BW'(DIV - 1);
  // The next byte leaves at the end of STOP so back-to-back frames have no gap.
  assign pop      = !empty && ((state == IDLE) || ((state == STOP) && baud_end));
  assign busy     = !empty || (state != IDLE);

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk    (clkFPGA),
    .rst    (rst),
    .wr_vld (push_req),
    .wr_dat (wdata[7:0]),
    .rd_rdy (pop),
    .rd_dat (fifo_dat),
    .full   (full),
    .empty  (empty),
    .count  (fcount)
  );

  // Set beats clear when an overflowing store meets a STATUS read.
  always_ff @(posedge clkFPGA) begin
    if (rst)                               ovf <= 1'b0;
    else if (push_req && full && !pop)     ovf <= 1'b1;
    else if (mem_re && stat_sel)           ovf <= 1'b0;
  end

  always_comb begin
    rdata = '0;
    if (stat_sel) begin
      rdata[0]    = full;
      rdata[1]    = empty;
      rdata[2]    = state != IDLE;
      rdata[3]    = ovf;
      rdata[4]    = PAR_EN;
      rdata[15:8] = 8'(fcount);
    end
  end

`ifdef MMIO_UART_TX_PARITY_EN
  logic par;
  always_ff @(posedge clkFPGA) begin
    if (pop) par <= ^fifo_dat;
  end
`endif

  always_ff @(posedge clkFPGA) begin
    if (rst) begin
      state <= IDLE;
      tx    <= 1'b1;
      shift <= '0;
      bitn  <= '0;
      baud  <= '0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          shift <= fifo_dat;
          bitn  <= '0;
          baud  <= '0;
          tx    <= 1'b0;
          state <= START;
        end
        START: if (baud_end) begin
          baud  <= '0;
          tx    <= shift[0];
          state <= DATA;
        end else baud <= baud + 1'b1;
        DATA: if (baud_end) begin
          baud <= '0;
          if (bitn == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
            tx    <= par;
            state <= PARITY;
`else
            tx    <= 1'b1;
            state <= STOP;
`endif
          end else begin
            bitn  <= bitn + 1'b1;
            shift <= shift >> 1;
            tx    <= shift[1];
          end
        end else baud <= baud + 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
        PARITY: if (baud_end) begin
          baud  <= '0;
          tx    <= 1'b1;
          state <= STOP;
        end else baud <= baud + 1'b1;
`endif
        STOP: if (baud_end) begin
          baud <= '0;
          if (pop) begin
            shift <= fifo_dat;
            bitn  <= '0;
            tx    <= 1'b0;
            state <= START;
          end else begin
            tx    <= 1'b1;
            state <= IDLE;
          end
        end else baud <= baud + 1'b1;
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed scenarios plus random bus traffic against a frame-level reference model.
module tb_mmio_uart_tx;
  localparam int          DIV   = 10;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0400;
  localparam logic [31:0] STAT  = 32'h0000_0401;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam int   NBITS = 11;
  localparam logic PAR   = 1'b1;
`else
  localparam int   NBITS = 10;
  localparam logic PAR   = 1'b0;
`endif

  logic        clkFPGA = 1'b0;
  logic        rst, mem_we, mem_re;
  logic [31:0] addr, wdata, rdata;
  logic        tx, busy;

  always #5 clkFPGA = ~clkFPGA;

  mmio_uart_tx #(.CLK_HZ(100), .BAUD(10), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clkFPGA (clkFPGA),
    .rst     (rst),
    .mem_we  (mem_we),
    .mem_re  (mem_re),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .tx      (tx),
    .busy    (busy)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  logic [7:0]  q[$];
  bit          m_active, m_ovf, m_valid;
  int          m_off;
  logic [7:0]  m_cur;
  logic [31:0] last_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Frame as a bit sequence: start, 8 data LSB first, [parity], stop.
  function automatic logic exp_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_off / DIV;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
    if (b == 9 && NBITS == 11) return ^m_cur;
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s       = '0;
    s[0]    = q.size() == DEPTH;
    s[1]    = q.size() == 0;
    s[2]    = m_active;
    s[3]    = m_ovf;
    s[4]    = PAR;
    s[15:8] = 8'(q.size());
    return s;
  endfunction

  task automatic model_edge(input logic r, input logic we, input logic re,
                            input logic [31:0] a, input logic [7:0] d);
    bit ovf_set;
    ovf_set = 0;
    if (r) begin
      q.delete();
      m_active = 0;
      m_off    = 0;
      m_ovf    = 0;
      return;
    end
    if (m_active) begin
      m_off++;
      if (m_off == NBITS * DIV) m_active = 0;
    end
    if (!m_active && q.size() > 0) begin
      m_cur    = q.pop_front();
      m_active = 1;
      m_off    = 0;
    end
    if (we && a == BASE) begin
      if (q.size() < DEPTH) q.push_back(d);
      else begin
        m_ovf   = 1;
        ovf_set = 1;
      end
    end
    if (re && a == STAT && !ovf_set) m_ovf = 0;
  endtask

  task automatic cycle(input logic r, input logic we, input logic re,
                       input logic [31:0] a, input logic [7:0] d);
    rst        = r;
    mem_we     = we;
    mem_re     = re;
    addr       = a;
    wdata      = $urandom();
    wdata[7:0] = d;
    @(negedge clkFPGA);
    last_rdata = rdata;
    if (m_valid) check("rdata", rdata, (a == STAT) ? exp_status() : 32'h0);
    @(posedge clkFPGA);
    model_edge(r, we, re, a, d);
    #1;
    if (m_valid) begin
      check("tx", tx, exp_tx());
      check("busy", busy, m_active || q.size() != 0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 32'h3FF + $urandom_range(0, 3), 8'h00);
  endtask

  logic [9:0] bits;
  int         lows;

  initial begin
    m_valid = 0;
    cycle(1'b1, 1'b0, 1'b0, STAT, 8'h00);
    m_valid = 1;
    repeat (2) cycle(1'b1, 1'b0, 1'b0, STAT, 8'h00);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    cycle(1'b0, 1'b0, 1'b1, STAT, 8'h00);
    check("rst_status", last_rdata, 32'h0000_0002);

    // Single 0x55, sampled mid-bit.
    cycle(1'b0, 1'b1, 1'b0, BASE, 8'h55);
    for (int k = 0; k < 10; k++) begin
      idle(k == 0 ? 5 : 10);
      bits[k] = tx;
    end
    check("u55_bits", bits, (NBITS == 11) ? 10'h0AA : 10'h2AA);
    idle(NBITS == 11 ? 20 : 10);
    check("u55_done", busy, 0);

    // Burst of four consecutive stores.
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, 1'b0, BASE, 8'(i));
    cycle(1'b0, 1'b0, 1'b1, STAT, 8'h00);
    check("burst_cnt", last_rdata[15:8], 3);
    idle(4 * NBITS * DIV + 10);
    check("burst_done", busy, 0);

    // Overflow while a frame is in flight.
    cycle(1'b0, 1'b1, 1'b0, BASE, 8'h11);
    idle(2);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, BASE, 8'($urandom()));
    cycle(1'b0, 1'b0, 1'b1, STAT, 8'h00);
    check("ovf_set", last_rdata[3], 1);
    check("ovf_full", last_rdata[15:8], 4);
    cycle(1'b0, 1'b0, 1'b1, STAT, 8'h00);
    check("ovf_clr", last_rdata[3], 0);
    idle(5 * NBITS * DIV + 10);

    // Reset 35 cycles into a 0xA5 frame.
    cycle(1'b0, 1'b1, 1'b0, BASE, 8'hA5);
    idle(35);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 8'h00);
    check("mrst_tx", tx, 1);
    check("mrst_busy", busy, 0);
    cycle(1'b0, 1'b0, 1'b1, STAT, 8'h00);
    check("mrst_status", last_rdata, 32'h0000_0002);
    lows = 0;
    for (int i = 0; i < 120; i++) begin
      idle(1);
      if (tx == 1'b0) lows++;
    end
    check("mrst_quiet", lows, 0);

`ifdef MMIO_UART_TX_PARITY_EN
    cycle(1'b0, 1'b1, 1'b0, BASE, 8'h07);
    idle(95);
    check("par_07", tx, 1);
    idle(20);
    cycle(1'b0, 1'b1, 1'b0, BASE, 8'h03);
    idle(95);
    check("par_03", tx, 0);
    idle(20);
`endif

    // Random bus traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        we, re, r;
      logic [31:0] a;
      we = $urandom_range(0, 39) == 0;
      re = $urandom_range(0, 7) == 0;
      r  = $urandom_range(0, 999) == 0;
      a  = 32'h3FF + $urandom_range(0, 3);
      if (we && $urandom_range(0, 1) == 1) a = BASE;
      cycle(r, we, re, a, 8'($urandom()));
    end
    idle(DEPTH * NBITS * DIV + NBITS * DIV);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
